clk_divider: RTL and testbench



---
 rtl/clk_divider.sv | 65 ++++++
 tb/tb_clk_divider.sv | 105 ++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// Integer clock divider: clk_out is a registered 50 %-duty square wave at f(clk_in)/(2*RATE).
// Optional checks are compiled in with `define CLK_DIVIDER_CHECK_EN.
module clk_divider #(
    parameter int RATE = 3
) (
    input  logic clk_in,
    input  logic rst,
    output logic clk_out
);

    localparam int unsigned CNT_W = (RATE > 1) ? $clog2(RATE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATE - 1);

    logic [CNT_W-1:0] cnt;
    logic             wrap_c;

    assign wrap_c = (cnt == CNT_LAST);

    // Half-period counter; clk_out flips each time the count wraps.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            clk_out <= 1'b0;
        end else if (wrap_c) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
        end else begin
            cnt     <= cnt + CNT_W'(1);
        end
    end

`ifdef CLK_DIVIDER_CHECK_EN
    if (RATE < 1) begin : g_rate_bad
        $error("clk_divider: RATE must be >= 1 (got %0d)", RATE);
    end

    logic seen_toggle;
    int   phase_len;

    // Each phase between toggles must last exactly RATE edges, once the first toggle is seen.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            seen_toggle <= 1'b0;
            phase_len   <= 0;
        end else if (wrap_c) begin
            if (seen_toggle) begin
                assert (phase_len + 1 == RATE)
                    else $error("clk_divider: phase lasted %0d cycles, RATE=%0d", phase_len + 1, RATE);
            end
            seen_toggle <= 1'b1;
            phase_len   <= 0;
        end else begin
            phase_len   <= phase_len + 1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            assert (cnt <= CNT_LAST)
                else $error("clk_divider: cnt=%0d exceeds RATE-1", cnt);
        end
    end
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Randomised bench for clk_divider: four RATE variants share one clock and reset and are
// compared against an edge-count reference model of the divided output.
module tb_clk_divider;

    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    logic out1, out3, out4, out5;

    int errors = 0;
    int checks = 0;
    int edges  = 0;   // rising clk_in edges since the last reset release

    clk_divider #(.RATE(1)) u_r1 (.clk_in(clk_in), .rst(rst), .clk_out(out1));
    clk_divider #(.RATE(3)) u_r3 (.clk_in(clk_in), .rst(rst), .clk_out(out3));
    clk_divider #(.RATE(4)) u_r4 (.clk_in(clk_in), .rst(rst), .clk_out(out4));
    clk_divider #(.RATE(5)) u_r5 (.clk_in(clk_in), .rst(rst), .clk_out(out5));

    task automatic check(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (edges=%0d t=%0t)", tag, got, exp, edges, $time);
        end
    endtask

    // Output after n edges: it has completed n/rate half-periods starting from low.
    function automatic logic model(input int rate, input int n);
        return ((n / rate) % 2) == 1;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_r1"}, out1, model(1, edges));
        check({tag, "_r3"}, out3, model(3, edges));
        check({tag, "_r4"}, out4, model(4, edges));
        check({tag, "_r5"}, out5, model(5, edges));
    endtask

    // One 20 ns (50 MHz) cycle: rising edge, high phase, falling edge, sample mid low phase.
    task automatic tick(input string tag);
        clk_in = 1'b1;
        if (rst) edges++;
        #10;
        clk_in = 1'b0;
        #5;
        check_all(tag);
        #5;
    endtask

    task automatic assert_rst_async(input string tag);
        #($urandom_range(4, 1));
        rst   = 1'b0;
        edges = 0;
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset for 2.75 cycles with clock running.
        #1;
        check_all("reset_state");
        tick("in_reset");
        tick("in_reset");
        #15;
        rst = 1'b1;
        #5;
        for (int i = 0; i < 24; i++) tick("run_first");

        // Reset mid high phase of RATE=3 (edges%6 == 4 means cnt=1 with out3 high).
        while ((edges % 6) != 4) tick("align");
        check("mid_high_pre_r3", out3, 1'b1);
        assert_rst_async("mid_high_async");
        for (int i = 0; i < 3; i++) tick("mid_high_hold");
        #1;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) tick("after_mid");

        // Reset with clk_in stopped.
        while (out5 !== 1'b1 && edges < 20) tick("pre_stop");
        assert_rst_async("stopped_async");
        #200;
        check_all("stopped_hold");
        rst = 1'b1;
        #50;
        check_all("stopped_release");
        for (int i = 0; i < 12; i++) tick("after_stop");

        // Random run lengths and reset pulses.
        for (int k = 0; k < 60; k++) begin
            int run_len;
            int hold;
            run_len = int'($urandom_range(40, 1));
            hold    = int'($urandom_range(3, 0));
            for (int i = 0; i < run_len; i++) tick("rand_run");
            assert_rst_async("rand_async");
            for (int i = 0; i < hold; i++) tick("rand_hold");
            #1;
            rst = 1'b1;
        end
        for (int i = 0; i < 40; i++) tick("tail");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
